// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the data BRAM between fetch and exec with a combinational grant that alternates on conflict.
// Read data returns RD_LAT cycles after ack; a requester without ack simply holds its request.
module mem_arbiter #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_req,
   input  logic [3:0]        ex_wea,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   output logic              ex_ack,
   output logic              ex_rvalid,
   output logic [DATA_W-1:0] ex_rdata,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              mem_enable,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wea,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} grant_t;

   grant_t            r_last_grant;
   logic [RD_LAT-1:0] r_vld;
   logic [RD_LAT-1:0] r_own;   // 1 = exec owns the slot

   logic w_grant_ex;
   logic w_grant_if;
   logic w_rd_push;

   // Exec wins a conflict only if fetch was granted most recently.
   assign w_grant_ex = !rst && ex_req && (!if_req || (r_last_grant == FETCH));
   assign w_grant_if = !rst && if_req && !w_grant_ex;
   assign w_rd_push  = w_grant_if || (w_grant_ex && (ex_wea == 4'b0000));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= FETCH;
         r_vld        <= '0;
         r_own        <= '0;
      end else begin
         if (w_grant_ex)
            r_last_grant <= EXEC;
         else if (w_grant_if)
            r_last_grant <= FETCH;
         r_vld[0] <= w_rd_push;
         r_own[0] <= w_grant_ex;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_own[i] <= r_own[i-1];
         end
      end
   end

   assign ex_ack     = w_grant_ex;
   assign if_ack     = w_grant_if;
   assign mem_enable = w_grant_ex || w_grant_if;
   assign mem_addr   = w_grant_ex ? ex_addr : (w_grant_if ? if_addr : '0);
   assign mem_wdata  = w_grant_ex ? ex_wdata : '0;
   assign mem_wea    = w_grant_ex ? ex_wea : 4'b0000;

   // Head of the tracking pipe lines up with the BRAM output word.
   assign ex_rvalid  = r_vld[RD_LAT-1] && r_own[RD_LAT-1];
   assign if_rvalid  = r_vld[RD_LAT-1] && !r_own[RD_LAT-1];
   assign ex_rdata   = mem_rdata;
   assign if_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter with a BRAM model and a queue-based scoreboard.
module tb_mem_arbiter;
   localparam int ADDR_W = 19;
   localparam int DATA_W = 32;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ex_req = 1'b0;
   logic [3:0]        ex_wea = 4'h0;
   logic [ADDR_W-1:0] ex_addr = '0;
   logic [DATA_W-1:0] ex_wdata = '0;
   logic              ex_ack, ex_rvalid;
   logic [DATA_W-1:0] ex_rdata;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_ack, if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              mem_enable;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_wea;
   logic [DATA_W-1:0] mem_rdata;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .ex_req(ex_req), .ex_wea(ex_wea), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .ex_ack(ex_ack), .ex_rvalid(ex_rvalid), .ex_rdata(ex_rdata),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wea(mem_wea), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // BRAM environment: read-first, RD_LAT cycles from enable edge to valid word.
   logic [DATA_W-1:0] bram [0:1023];
   logic [DATA_W-1:0] pipe [0:RD_LAT-1];
   assign mem_rdata = pipe[RD_LAT-1];
   always @(posedge clk) begin
      if (mem_enable) begin
         pipe[0] <= bram[mem_addr[9:0]];
         for (int b = 0; b < 4; b++)
            if (mem_wea[b]) bram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end

   // Reference model state
   typedef struct { logic [DATA_W-1:0] d; int due; } exp_t;
   exp_t q_ex[$];
   exp_t q_if[$];
   logic [DATA_W-1:0] shadow [0:1023];
   int  m_last_exec = 0;
   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;
   logic a_ex, a_if;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         bram[i]   = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
         shadow[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
      end
      for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
   end

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, req, cyc);
      end
   endtask

   task automatic check_rv(input string nm, input logic rv, input logic [DATA_W-1:0] rd,
                           inout exp_t q[$]);
      logic exp_rv;
      exp_rv = (q.size() > 0) && (q[0].due == cyc);
      chk({nm, "_rvalid"}, rv, exp_rv);
      if (exp_rv) begin
         chk({nm, "_rdata"}, rd, q[0].d);
         void'(q.pop_front());
      end
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      logic exp_ex, exp_if;
      exp_t e;
      if (rst) begin
         chk("rst_ex_ack", ex_ack, 0);
         chk("rst_if_ack", if_ack, 0);
         chk("rst_mem_enable", mem_enable, 0);
         chk("rst_mem_wea", mem_wea, 0);
         chk("rst_ex_rvalid", ex_rvalid, 0);
         chk("rst_if_rvalid", if_rvalid, 0);
         q_ex.delete();
         q_if.delete();
         m_last_exec = 0;
      end else begin
         check_rv("ex", ex_rvalid, ex_rdata, q_ex);
         check_rv("if", if_rvalid, if_rdata, q_if);
         exp_ex = ex_req && (!if_req || m_last_exec == 0);
         exp_if = if_req && !exp_ex;
         chk("ex_ack", ex_ack, exp_ex);
         chk("if_ack", if_ack, exp_if);
         chk("mem_enable", mem_enable, exp_ex | exp_if);
         if (exp_ex) begin
            chk("mem_addr_ex", mem_addr, ex_addr);
            chk("mem_wea_ex", mem_wea, ex_wea);
            chk("mem_wdata_ex", mem_wdata, ex_wdata);
            if (ex_wea == 4'h0) begin
               e.d = shadow[ex_addr[9:0]]; e.due = cyc + RD_LAT;
               q_ex.push_back(e);
            end else begin
               for (int b = 0; b < 4; b++)
                  if (ex_wea[b]) shadow[ex_addr[9:0]][8*b +: 8] = ex_wdata[8*b +: 8];
            end
            m_last_exec = 1;
         end else if (exp_if) begin
            chk("mem_addr_if", mem_addr, if_addr);
            chk("mem_wea_if", mem_wea, 0);
            e.d = shadow[if_addr[9:0]]; e.due = cyc + RD_LAT;
            q_if.push_back(e);
            m_last_exec = 0;
         end else begin
            chk("idle_mem_addr", mem_addr, 0);
            chk("idle_mem_wea", mem_wea, 0);
            chk("idle_mem_wdata", mem_wdata, 0);
         end
      end
   end

   // Capture acks of the current cycle, then move to just after the next edge.
   task automatic tick();
      @(negedge clk);
      a_ex = ex_ack;
      a_if = if_ack;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; ex_req = 1'b1; if_req = 1'b1; ex_wea = 4'h0;
      repeat (2) tick();
      rst = 1'b0; ex_req = 1'b0; if_req = 1'b0;
   endtask

   task automatic idle(input int n);
      ex_req = 1'b0; if_req = 1'b0;
      repeat (n) tick();
   endtask

   task automatic new_ex();
      ex_req   = ($urandom_range(0, 3) != 0);
      ex_addr  = ADDR_W'($urandom_range(0, 15));
      ex_wea   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      ex_wdata = $urandom;
   endtask

   initial begin
      do_reset();
      // T1: lone exec read
      ex_req = 1'b1; ex_wea = 4'h0; ex_addr = 19'h100;
      tick();
      chk("t1_ack_seen", a_ex, 1);
      idle(RD_LAT + 2);

      // T2: simultaneous requests straight out of reset
      do_reset();
      ex_req = 1'b1; ex_addr = 19'h3; if_req = 1'b1; if_addr = 19'h4;
      for (int k = 0; k < 8 && (ex_req || if_req); k++) begin
         tick();
         if (a_ex) ex_req = 1'b0;
         if (a_if) if_req = 1'b0;
      end
      idle(RD_LAT + 2);

      // T3: both held six grants, fields advance on ack
      do_reset();
      ex_req = 1'b1; ex_addr = 19'h10; if_req = 1'b1; if_addr = 19'h20;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (a_ex) ex_addr = ex_addr + 1;
         if (a_if) if_addr = if_addr + 1;
      end
      idle(RD_LAT + 2);

      // T4: exec write then fetch read of same word
      ex_req = 1'b1; ex_wea = 4'hF; ex_addr = 19'h20; ex_wdata = 32'hDEADBEEF;
      tick();
      ex_req = 1'b0; ex_wea = 4'h0; if_req = 1'b1; if_addr = 19'h20;
      tick();
      idle(RD_LAT + 2);

      // T5: reset pulse right after an exec read ack
      ex_req = 1'b1; ex_addr = 19'h40;
      tick();
      ex_req = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; ex_req = 1'b1; ex_addr = 19'h41;
      tick();
      chk("t5_ack_after_rst", a_ex, 1);
      idle(RD_LAT + 2);

      // T6: exec cancels while fetch streams
      ex_req = 1'b1; ex_wea = 4'hF; ex_addr = 19'h5; ex_wdata = 32'h12345678;
      tick();
      ex_wea = 4'h0; ex_addr = 19'h6; if_req = 1'b1; if_addr = 19'h7;
      tick();
      ex_req = 1'b0; if_addr = 19'h8;
      tick();
      if_addr = 19'h9;
      tick();
      idle(RD_LAT + 2);

      // Random traffic with legal cancels and one mid-run reset
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         tick();
         if (a_ex || !ex_req) new_ex();
         else if ($urandom_range(0, 15) == 0) ex_req = 1'b0;
         if (a_if || !if_req) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = ADDR_W'($urandom_range(0, 15));
         end else if ($urandom_range(0, 15) == 0) if_req = 1'b0;
      end
      idle(RD_LAT + 4);
      chk("ex_queue_drained", q_ex.size(), 0);
      chk("if_queue_drained", q_if.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
